// File: rtl/dm_responder_pkg.sv
// ============================================================================
// Module : dm_responder_pkg
// Brief  : Shared types, defaults and byte-merge helper for the data-memory responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dm_responder_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_e;

  localparam int DM_DEPTH_WORDS = 3072;
  localparam int DM_WAIT_CYCLES = 2;
  localparam int DM_BE_W        = 4;

  function automatic logic [31:0] dm_merge(input logic [31:0]        old_word,
                                           input logic [31:0]        new_word,
                                           input logic [DM_BE_W-1:0] be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < DM_BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_array.sv
// ============================================================================
// Module : dm_array
// Brief  : Word storage with combinational read and byte-enable write; async clear.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_array
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [DM_BE_W-1:0] i_be,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < DM_BE_W; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Callers only trust this when the index has passed the range check.
  assign o_rdata = r_mem[i_idx];

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// ============================================================================
// Module : dm_responder
// Brief  : Single-outstanding data-memory target with fixed wait latency.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int          WAIT_CYCLES = DM_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [DM_BE_W-1:0] req_be,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [31:0]        req_pc,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_err
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  C_WAIT   = WAIT_CYCLES[3:0];
  localparam logic [29:0] C_BASE_W = BASE_ADDR[31:2];
  localparam logic [29:0] C_DEPTH  = DEPTH_WORDS[29:0];

  dm_state_e          r_state;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [DM_BE_W-1:0] r_be;
  logic [31:0]        r_addr, r_wdata, r_pc;
  logic               r_resp_valid, r_resp_err;
  logic [31:0]        r_resp_rdata;

  logic               w_idle, w_commit, w_we, w_err;
  logic [DM_BE_W-1:0] w_be;
  logic [31:0]        w_addr, w_wdata, w_pc, w_old, w_new;
  logic [29:0]        w_word_off;

  assign w_idle = (r_state == DM_IDLE);

  // With zero wait the commit happens on the accept edge, so the live request is used.
  assign w_we    = w_idle ? req_we    : r_we;
  assign w_be    = w_idle ? req_be    : r_be;
  assign w_addr  = w_idle ? req_addr  : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_pc    = w_idle ? req_pc    : r_pc;

  assign w_commit = (w_idle && req_valid && (C_WAIT == 4'd0)) ||
                    ((r_state == DM_WAIT) && (r_cnt == 4'd1));

  assign w_word_off = w_addr[31:2] - C_BASE_W;
  assign w_err      = (w_addr[1:0] != 2'b00) || (w_addr < BASE_ADDR) || (w_word_off >= C_DEPTH);
  assign w_new      = dm_merge(w_old, w_wdata, w_be);

  dm_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_commit && w_we && !w_err),
    .i_be    (w_be),
    .i_idx   (w_word_off[IDX_W-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_old)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= DM_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pc         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        DM_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_be    <= req_be;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_pc    <= req_pc;
            r_cnt   <= C_WAIT;
            r_state <= (C_WAIT == 4'd0) ? DM_RESP : DM_WAIT;
          end
        end
        DM_WAIT: begin
          if (r_cnt == 4'd1) r_state <= DM_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        DM_RESP: begin
          r_state      <= DM_IDLE;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        default: r_state <= DM_IDLE;
      endcase
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_resp_rdata <= (!w_we && !w_err) ? w_old : 32'h0;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_we && !w_err && (w_be != '0))
      $display("%d@%h: *%h <= %h", $time, w_pc, w_addr, w_new);
  end
`endif

  assign req_ready  = w_idle;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// Module : tb_dm_responder
// Brief  : Directed self-checking bench for dm_responder (WAIT_CYCLES=2 and 0 builds).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          total = 0;
  int          bad   = 0;

  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        z_valid = 1'b0, z_we = 1'b0;
  logic [3:0]  z_be = 4'h0;
  logic [31:0] z_addr = '0, z_wdata = '0, z_pc = '0;
  logic        z_ready, z_rvalid, z_err;
  logic [31:0] z_rdata;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we), .req_be(z_be),
    .req_addr(z_addr), .req_wdata(z_wdata), .req_pc(z_pc),
    .resp_valid(z_rvalid), .resp_rdata(z_rdata), .resp_err(z_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; lat = edges from accept to response.
  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int lat);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr;
    req_wdata = wdata; req_pc = 32'h0000_1000 + addr;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 32'hFFFF_FFFF; req_wdata = '0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) lat = -1;
    rdata = resp_rdata;
    err   = resp_err;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h, want 1 0 00000000",
               req_ready, resp_valid, resp_rdata);
    end
    txn(1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 2) begin
      bad++;
      $display("FAIL reset_load0: rdata=%h err=%b lat=%0d, want 00000000 0 2", rd, er, lat);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 4'hF, 32'h10, 32'h1234_5678, rd, er, lat);
    total++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
      bad++;
      $display("FAIL store_resp: lat=%0d err=%b rdata=%h, want 2 0 00000000", lat, er, rd);
    end
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL store_pulse_width: valid=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
    txn(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h1234_5678 || er !== 1'b0) begin
      bad++;
      $display("FAIL load_after_store: rdata=%h err=%b, want 12345678 0", rd, er);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 4'b0010, 32'h10, 32'h0000_AB00, rd, er, lat);
    txn(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h1234_AB78) begin
      bad++;
      $display("FAIL be_0010: rdata=%h, want 1234ab78", rd);
    end
    txn(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, rd, er, lat);
    total++;
    if (lat != 2 || er !== 1'b0) begin
      bad++;
      $display("FAIL be_0000_resp: lat=%0d err=%b, want 2 0", lat, er);
    end
    txn(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h1234_AB78) begin
      bad++;
      $display("FAIL be_0000_unchanged: rdata=%h, want 1234ab78", rd);
    end
    txn(1'b1, 4'b1000, 32'h10, 32'hCD00_0000, rd, er, lat);
    txn(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'hCD34_AB78) begin
      bad++;
      $display("FAIL be_1000: rdata=%h, want cd34ab78", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 4'hF, 32'h12, 32'hFFFF_FFFF, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin
      bad++;
      $display("FAIL err_store_misaligned: err=%b rdata=%h lat=%0d, want 1 00000000 2", er, rd, lat);
    end
    txn(1'b0, 4'h0, 32'h12, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL err_load_misaligned: err=%b rdata=%h, want 1 00000000", er, rd);
    end
    txn(1'b0, 4'h0, 32'h3000, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++;
      $display("FAIL err_load_range: err=%b rdata=%h, want 1 00000000", er, rd);
    end
    txn(1'b1, 4'hF, 32'h2FFC, 32'hA5A5_5A5A, rd, er, lat);
    txn(1'b0, 4'h0, 32'h2FFC, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'hA5A5_5A5A) begin
      bad++;
      $display("FAIL last_word: err=%b rdata=%h, want 0 a5a55a5a", er, rd);
    end
    txn(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'hCD34_AB78) begin
      bad++;
      $display("FAIL err_no_change: err=%b rdata=%h, want 0 cd34ab78", er, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] rdy, rv, rdy_exp, rv_exp;
    logic        data_ok;
    rdy_exp = 12'b0001_0001_0001;
    rv_exp  = 12'b1000_1000_1000;
    data_ok = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'h0; req_addr = 32'h10;
    for (int i = 0; i < 12; i++) begin
      rdy[i] = req_ready;
      rv[i]  = resp_valid;
      if (resp_valid && resp_rdata !== 32'hCD34_AB78) data_ok = 1'b0;
      tick();
    end
    req_valid = 1'b0;
    total++;
    if (rdy !== rdy_exp) begin
      bad++;
      $display("FAIL b2b_ready: pattern=%b, want %b", rdy, rdy_exp);
    end
    total++;
    if (rv !== rv_exp) begin
      bad++;
      $display("FAIL b2b_resp: pattern=%b, want %b", rv, rv_exp);
    end
    total++;
    if (!data_ok) begin
      bad++;
      $display("FAIL b2b_data: a response returned data other than cd34ab78");
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    logic        saw;
    saw = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h20;
    req_wdata = 32'hDEAD_BEEF; req_pc = 32'h0000_2000;
    tick();
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_async: ready=%b valid=%b, want 1 0", req_ready, resp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid) saw = 1'b1;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) saw = 1'b1;
      tick();
    end
    total++;
    if (saw) begin
      bad++;
      $display("FAIL abort_no_pulse: resp_valid seen=1, want 0");
    end
    txn(1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_commit: rdata=%h err=%b, want 00000000 0", rd, er);
    end
    txn(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL abort_array_cleared: rdata=%h, want 00000000", rd);
    end
  endtask

  task automatic test_wait0();
    logic [7:0] rdy, rv;
    logic       data_ok;
    z_valid = 1'b1; z_we = 1'b1; z_be = 4'hF; z_addr = 32'h40;
    z_wdata = 32'h55AA_55AA; z_pc = 32'h0000_3000;
    tick();
    z_valid = 1'b0; z_we = 1'b0; z_be = 4'h0;
    total++;
    if (z_rvalid !== 1'b1 || z_err !== 1'b0 || z_ready !== 1'b0) begin
      bad++;
      $display("FAIL w0_store_latency: valid=%b err=%b ready=%b, want 1 0 0", z_rvalid, z_err, z_ready);
    end
    tick();
    data_ok = 1'b1;
    z_valid = 1'b1; z_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      rdy[i] = z_ready;
      rv[i]  = z_rvalid;
      if (z_rvalid && z_rdata !== 32'h55AA_55AA) data_ok = 1'b0;
      tick();
    end
    z_valid = 1'b0;
    total++;
    if (rdy !== 8'b0101_0101 || rv !== 8'b1010_1010) begin
      bad++;
      $display("FAIL w0_b2b: ready=%b resp=%b, want 01010101 10101010", rdy, rv);
    end
    total++;
    if (!data_ok) begin
      bad++;
      $display("FAIL w0_load_data: a response returned data other than 55aa55aa");
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_wait0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
